// File: rtl/aes_gcm_pkg.sv
// Shared types and helpers for the GCM GHASH/tag engine.
// Block vectors are [127:0] with bit 127 holding GCM bit 0 (the x^0 coefficient).
package aes_gcm_pkg;

  typedef enum logic [2:0] {IDLE, AAD, CT, LEN, TAG} ghash_state_t;

  localparam logic [127:0] GF_R = 128'hE1 << 120;

  typedef logic [127:0] block_t;

  // Keep the first r message bits of a block; r == 0 means a full block.
  function automatic block_t fn_mask_block(block_t b, int r);
    block_t keep;
    keep = '1;
    if (r > 0 && r < 128) keep = ~(keep >> r);
    return b & keep;
  endfunction

endpackage

// File: rtl/gf128_digit_mult.sv
// GF(2^128) multiplier in GCM bit order, DIGIT_W bits of X per cycle, 128/DIGIT_W cycles.
// The first digit is folded in on the start edge so o_busy clears in the cycle o_done pulses.
module gf128_digit_mult
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [127:0] i_x,
  input  logic [127:0] i_h,
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_z
);
  localparam int M  = 128 / DIGIT_W;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  block_t        r_x, r_v, r_z;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_done;

  logic   w_load;
  block_t w_x, w_v, w_z;

  always_comb begin
    w_load = i_start && !r_busy;
    w_x    = w_load ? i_x : r_x;
    w_v    = w_load ? i_h : r_v;
    w_z    = w_load ? '0  : r_z;
    for (int j = 0; j < DIGIT_W; j++) begin
      if (w_x[127-j]) w_z = w_z ^ w_v;
      w_v = w_v[0] ? ((w_v >> 1) ^ GF_R) : (w_v >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_v    <= '0;
      r_z    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_z   <= w_z;
        r_v   <= w_v;
        r_x   <= i_x << DIGIT_W;
        r_cnt <= CW'(1);
        if (M == 1) r_done <= 1'b1;
        else        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_z   <= w_z;
        r_v   <= w_v;
        r_x   <= r_x << DIGIT_W;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(M - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_z    = r_z;
endmodule

// File: rtl/aes_gcm_ghash_engine.sv
// Streaming GHASH/tag engine: AAD then CT blocks over valid/ready, length block, tag = MSBs(S ^ E(K,J0)).
// One block per 128/DIGIT_W cycles; tag valid 2M+1 cycles after the last block, held until accepted.
module aes_gcm_ghash_engine
  import aes_gcm_pkg::*;
#(
  parameter int DIGIT_W = 8,
  parameter int TAG_W   = 128,
  parameter int LEN_W   = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [127:0]     i_h,
  input  logic [127:0]     i_encrypted_j0,
  input  logic [LEN_W-1:0] i_aad_bits,
  input  logic [LEN_W-1:0] i_ct_bits,
  input  logic [127:0]     i_blk,
  input  logic             i_blk_valid,
  output logic             o_blk_ready,
  output logic             o_busy,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_tag_valid,
  input  logic             i_tag_ready
);
  localparam int CNT_W = LEN_W - 7 + 1;

  ghash_state_t     r_state, w_state_nxt;
  block_t           r_h, r_ej0, r_s;
  logic [LEN_W-1:0] r_aad_bits, r_ct_bits;
  logic [CNT_W-1:0] r_na, r_nc;
  logic             r_len_go;
  logic [TAG_W-1:0] r_tag;
  logic             r_tag_vld;

  logic             w_mult_busy, w_mult_done, w_mult_start;
  block_t           w_mult_z, w_mult_x, w_s_cur, w_tag_full;
  logic             w_start, w_xfer, w_last, w_len_start, w_len_done;
  logic [6:0]       w_rem;
  logic [CNT_W-1:0] w_na_init, w_nc_init;

  always_comb begin
    w_start     = (r_state == IDLE) && i_start;
    w_na_init   = {1'b0, i_aad_bits[LEN_W-1:7]} + {{(CNT_W-1){1'b0}}, |i_aad_bits[6:0]};
    w_nc_init   = {1'b0, i_ct_bits[LEN_W-1:7]} + {{(CNT_W-1){1'b0}}, |i_ct_bits[6:0]};
    o_blk_ready = ((r_state == AAD) || (r_state == CT)) && !w_mult_busy;
    w_xfer      = o_blk_ready && i_blk_valid;
    w_last      = (r_state == AAD) ? (r_na == CNT_W'(1)) : (r_nc == CNT_W'(1));
    w_rem       = (r_state == AAD) ? r_aad_bits[6:0] : r_ct_bits[6:0];
    // The product lands in r_s one cycle after done; forward it so back-to-back blocks see it.
    w_s_cur     = w_mult_done ? w_mult_z : r_s;
    w_len_start = (r_state == LEN) && !r_len_go && !w_mult_busy;
    w_len_done  = (r_state == LEN) && r_len_go && w_mult_done;
    w_mult_start = w_xfer || w_len_start;
    w_mult_x    = w_s_cur ^ (w_xfer ? fn_mask_block(i_blk, w_last ? int'(w_rem) : 0)
                                    : {64'(r_aad_bits), 64'(r_ct_bits)});
    w_tag_full  = w_mult_z ^ r_ej0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = (|i_aad_bits) ? AAD : ((|i_ct_bits) ? CT : LEN);
      AAD:  if (w_xfer && w_last) w_state_nxt = (r_nc != '0) ? CT : LEN;
      CT:   if (w_xfer && w_last) w_state_nxt = LEN;
      LEN:  if (w_len_done) w_state_nxt = TAG;
      TAG:  if (i_tag_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h        <= '0;
      r_ej0      <= '0;
      r_s        <= '0;
      r_aad_bits <= '0;
      r_ct_bits  <= '0;
      r_na       <= '0;
      r_nc       <= '0;
      r_len_go   <= 1'b0;
      r_tag      <= '0;
      r_tag_vld  <= 1'b0;
    end else begin
      if (w_start) begin
        r_h        <= i_h;
        r_ej0      <= i_encrypted_j0;
        r_aad_bits <= i_aad_bits;
        r_ct_bits  <= i_ct_bits;
        r_na       <= w_na_init;
        r_nc       <= w_nc_init;
        r_s        <= '0;
        r_len_go   <= 1'b0;
      end else begin
        if (w_mult_done) r_s <= w_mult_z;
        if (w_xfer) begin
          if (r_state == AAD) r_na <= r_na - 1'b1;
          else                r_nc <= r_nc - 1'b1;
        end
        if (w_len_start) r_len_go <= 1'b1;
        if (w_len_done)  r_tag <= w_tag_full[127 -: TAG_W];
      end
      r_tag_vld <= (w_state_nxt == TAG);
    end
  end

  gf128_digit_mult #(.DIGIT_W(DIGIT_W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mult_start),
    .i_x     (w_mult_x),
    .i_h     (w_start ? i_h : r_h),
    .o_busy  (w_mult_busy),
    .o_done  (w_mult_done),
    .o_z     (w_mult_z)
  );

  assign o_busy      = (r_state != IDLE);
  assign o_tag       = r_tag;
  assign o_tag_valid = r_tag_vld;
endmodule

// File: tb/tb_aes_gcm_ghash_engine.sv
// Three engines (DIGIT_W 8/1/128, the last with a 96-bit tag) driven one at a time from directed
// NIST vectors and random messages, checked against a polynomial-arithmetic GHASH model.
module tb_aes_gcm_ghash_engine;

  function automatic int dw_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 1 : 128);
  endfunction
  function automatic int tw_of(input int d);
    return (d == 2) ? 96 : 128;
  endfunction

  logic         clk, rst;
  logic         start [3];
  logic [127:0] h     [3];
  logic [127:0] ej0   [3];
  logic [38:0]  aadb  [3];
  logic [38:0]  ctb   [3];
  logic [127:0] blk   [3];
  logic         bvld  [3];
  logic         trdy  [3];
  wire          brdy  [3];
  wire          busy  [3];
  wire          tvld  [3];
  wire  [127:0] tag   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = dw_of(g);
    localparam int TW = tw_of(g);
    logic [TW-1:0] w_tag;
    aes_gcm_ghash_engine #(.DIGIT_W(DW), .TAG_W(TW), .LEN_W(39)) u_dut (
      .clk(clk), .rst(rst), .i_start(start[g]), .i_h(h[g]), .i_encrypted_j0(ej0[g]),
      .i_aad_bits(aadb[g]), .i_ct_bits(ctb[g]), .i_blk(blk[g]), .i_blk_valid(bvld[g]),
      .o_blk_ready(brdy[g]), .o_busy(busy[g]), .o_tag(w_tag), .o_tag_valid(tvld[g]),
      .i_tag_ready(trdy[g]));
    assign tag[g] = 128'(w_tag) << (128 - TW);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [127:0] msg_q[$];

  task automatic chk_v(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Carry-less product of the two polynomials, reduced by x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p;
    logic [127:0] ar, br;
    ar = rev128(a);
    br = rev128(b);
    p  = '0;
    for (int i = 0; i < 128; i++) if (ar[i]) p = p ^ (255'(br) << i);
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i] = 1'b0;
        p    = p ^ (255'(8'h87) << (i - 128));
      end
    end
    return rev128(p[127:0]);
  endfunction

  function automatic logic [127:0] model_tag(input logic [127:0] hh, input logic [127:0] ej,
                                             input int aad, input int ct);
    logic [127:0] y, b;
    int na, nc, r;
    na = (aad + 127) / 128;
    nc = (ct + 127) / 128;
    y  = '0;
    for (int i = 0; i < na + nc; i++) begin
      b = msg_q[i];
      if (i < na) r = (i == na - 1) ? aad - 128 * i : 128;
      else        r = (i == na + nc - 1) ? ct - 128 * (i - na) : 128;
      for (int k = r; k < 128; k++) b[127-k] = 1'b0;
      y = gf_mul(y ^ b, hh);
    end
    y = gf_mul(y ^ {64'(aad), 64'(ct)}, hh);
    return y ^ ej;
  endfunction

  function automatic logic [127:0] tw_mask(input int d);
    logic [127:0] ones;
    ones = '1;
    return ~(ones >> tw_of(d));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] H0   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EJ0A = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] H4   = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] EJ04 = 128'h3247184b3c4f69a44dbcd22887bbb418;
  localparam logic [127:0] TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] TAG4 = 128'h5bc94fbc3221a5db94fae95ae7121a47;

  task automatic load_tc2();
    msg_q.delete();
    msg_q.push_back(128'h0388dace60b6a392f328c2b971b2fe78);
  endtask

  task automatic load_tc4();
    logic [127:0] g;
    msg_q.delete();
    g = rnd128();
    msg_q.push_back(128'hfeedfacedeadbeeffeedfacedeadbeef);
    msg_q.push_back({32'habaddad2, g[95:0]});
    msg_q.push_back(128'h42831ec2217774244b7221b784d0d49c);
    msg_q.push_back(128'he3aa212f2c02a4e035c17e2329aca12e);
    msg_q.push_back(128'h21d514b25466931c7d8f6a5aac84aa05);
    msg_q.push_back({96'h1ba30b396a0aac973d58e091, g[127:96]});
  endtask

  task automatic run_msg(input int d, input logic [127:0] hh, input logic [127:0] ej,
                         input int aad, input int ct, input bit stall, input bit poke,
                         input int abort_at, output logic [127:0] tag_out);
    int nblk, bi, gap, guard, lat, extra, mm;
    bit rdy, acc, seen;
    logic [127:0] t0;
    mm      = 128 / dw_of(d);
    nblk    = msg_q.size();
    tag_out = '0;
    @(negedge clk);
    start[d] = 1'b1; h[d] = hh; ej0[d] = ej; aadb[d] = 39'(aad); ctb[d] = 39'(ct);
    @(negedge clk);
    start[d] = 1'b0;
    bi = 0; gap = -1; guard = 0;
    while (bi < nblk && bi != abort_at && guard < 20000) begin
      blk[d]   = msg_q[bi];
      bvld[d]  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      start[d] = poke && (bi == 1);
      h[d]     = (poke && bi == 1) ? ~hh : hh;
      #1;
      rdy = brdy[d];
      if (gap >= 0 && rdy) begin
        chk_i("blk_ready_gap", gap, mm - 1);
        gap = -1;
      end else if (gap >= 0) gap++;
      if (rdy && bvld[d]) begin
        bi++;
        gap = 0;
      end
      guard++;
      @(negedge clk);
    end
    start[d] = 1'b0; bvld[d] = 1'b0; h[d] = hh;
    if (abort_at >= 0) return;
    chk_i("blocks_accepted", bi, nblk);
    lat = 0; extra = 0; seen = 1'b0;
    while (!seen && lat < 3000) begin
      #1;
      lat++;
      if (brdy[d]) extra++;
      if (tvld[d]) seen = 1'b1;
      else @(negedge clk);
    end
    chk_i("tag_valid_seen", int'(seen), 1);
    chk_i("no_ready_after_last", extra, 0);
    if (nblk > 0) chk_i("tag_latency", lat, 2 * mm + 1);
    t0 = tag[d];
    tag_out = t0;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 200) begin
      trdy[d] = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
      acc = trdy[d];
      @(negedge clk);
      #1;
      if (!acc) begin
        chk_i("tag_valid_hold", int'(tvld[d]), 1);
        chk_v("tag_stable", tag[d], t0);
      end
      guard++;
    end
    trdy[d] = 1'b0;
    chk_i("tag_valid_drop", int'(tvld[d]), 0);
    chk_i("idle_after_accept", int'(busy[d]), 0);
  endtask

  initial begin
    logic [127:0] t, hr, er;
    int aad, ct;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 0; h[d] = '0; ej0[d] = '0; aadb[d] = '0; ctb[d] = '0;
      blk[d] = '0; bvld[d] = 0; trdy[d] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_i("rst_blk_ready", int'(brdy[d]), 0);
      chk_i("rst_busy", int'(busy[d]), 0);
      chk_i("rst_tag_valid", int'(tvld[d]), 0);
      chk_v("rst_tag", tag[d], '0);
    end
    rst = 1'b0;

    msg_q.delete();
    run_msg(0, H0, EJ0A, 0, 0, 1'b0, 1'b0, -1, t);
    chk_v("tc1_tag", t, EJ0A);

    load_tc2();
    run_msg(0, H0, EJ0A, 0, 128, 1'b0, 1'b0, -1, t);
    chk_v("tc2_tag", t, TAG2);

    load_tc4();
    run_msg(0, H4, EJ04, 160, 480, 1'b0, 1'b0, -1, t);
    chk_v("tc4_tag_dw8", t, TAG4);

    load_tc4();
    run_msg(0, H4, EJ04, 160, 480, 1'b1, 1'b0, -1, t);
    chk_v("tc4_tag_dw8_stall", t, TAG4);

    load_tc4();
    run_msg(1, H4, EJ04, 160, 480, 1'b1, 1'b0, -1, t);
    chk_v("tc4_tag_dw1_stall", t, TAG4);

    load_tc4();
    run_msg(2, H4, EJ04, 160, 480, 1'b1, 1'b0, -1, t);
    chk_v("tc4_tag_dw128_stall", t, TAG4 & tw_mask(2));

    load_tc2();
    run_msg(2, H0, EJ0A, 0, 128, 1'b0, 1'b0, -1, t);
    chk_v("tc2_tag96", t, 128'hab6e47d42cec13bdf53a67b2_00000000);

    // Reset while the second ciphertext block is on offer, then a clean TC2.
    load_tc4();
    run_msg(0, H4, EJ04, 160, 480, 1'b0, 1'b0, 3, t);
    rst = 1'b1;
    #1;
    chk_i("midrst_blk_ready", int'(brdy[0]), 0);
    chk_i("midrst_busy", int'(busy[0]), 0);
    chk_i("midrst_tag_valid", int'(tvld[0]), 0);
    chk_v("midrst_tag", tag[0], '0);
    @(negedge clk);
    rst = 1'b0;
    load_tc2();
    run_msg(0, H0, EJ0A, 0, 128, 1'b1, 1'b0, -1, t);
    chk_v("tc2_after_rst", t, TAG2);

    load_tc4();
    run_msg(0, H4, EJ04, 160, 480, 1'b0, 1'b1, -1, t);
    chk_v("tc4_start_poke", t, TAG4);

    @(negedge clk);
    bvld[0] = 1'b1;
    #1;
    chk_i("idle_valid_ignored", int'(brdy[0]), 0);
    @(negedge clk);
    #1;
    chk_i("idle_valid_not_busy", int'(busy[0]), 0);
    bvld[0] = 1'b0;

    for (int k = 0; k < 9; k++) begin
      int d;
      d   = k % 3;
      aad = (k == 3) ? 256 : int'($urandom_range(0, 400));
      ct  = (k == 4) ? 0 : int'($urandom_range(0, (d == 1) ? 300 : 700));
      hr  = rnd128();
      er  = rnd128();
      msg_q.delete();
      for (int i = 0; i < (aad + 127) / 128 + (ct + 127) / 128; i++) msg_q.push_back(rnd128());
      run_msg(d, hr, er, aad, ct, k[0], 1'b0, -1, t);
      chk_v("rand_tag", t, model_tag(hr, er, aad, ct) & tw_mask(d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
